// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/stall controller driving the PC and pipeline-register enables and flushes.
// Optional performance counters (stall_cnt, flush_cnt) are built only when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MDU_LAT    = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mdu_start,
  input  logic                  mem_stall,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  idex_we,
  output logic                  exmem_we,
  output logic                  memwb_we,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  memwb_flush,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // cnt only has to hold MDU_LAT-2, the stalls left after the mdu_start cycle.
  localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT - 1) : 1;
  localparam logic [CW-1:0] MDU_LOAD = CW'((MDU_LAT > 1) ? MDU_LAT - 2 : 0);

  typedef enum logic [1:0] {RUN, MDU_BUSY, HALT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load_use;
  logic            mdu_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    load_use    = ex_mem_read && (ex_rd != '0) &&
                  ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
    mdu_stall   = ((state_q == RUN) && mdu_start && (MDU_LAT > 1)) ||
                  ((state_q == MDU_BUSY) && (cnt_q != '0));

    if (!rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (mem_stall || (state_q == HALT) || ((state_q == RUN) && halt_req)) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
      if (!mem_stall) begin
        if (state_q == HALT) begin
          if (resume) state_d = RUN;
        end else begin
          state_d = HALT;
        end
      end
    end else if (mdu_stall) begin
      // Hold the front end and drain a bubble into EX/MEM while the MDU works.
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_flush = 1'b1;
      if (state_q == RUN) begin
        cnt_d   = MDU_LOAD;
        state_d = MDU_BUSY;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else if (state_q == MDU_BUSY) begin
      state_d = RUN;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign halted = (state_q == HALT);

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_we && (state_q != HALT)) stall_q <= stall_q + CNT_W'(1);
      if (ifid_flush || idex_flush || exmem_flush || memwb_flush) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
